axis_serdes_tx: RTL and testbench

Serializing transmitter for the AXI-Stream SERDES link. It accepts 32-bit words on an AXI-Stream slave port and drives them onto a single serial line as framed bits: start, 32 data bits LSB first, even parity, stop. After reset it emits a training toggle pattern so the multi-phase receiver can pick a sampling phase before any data arrives. It sits on the TX side of the link and is the counterpart of the deserializing receiver in `top_axi_serdes`.

---
 rtl/axis_serdes_tx_if.sv | 8 +
 rtl/axis_serdes_tx.sv | 95 +++++++++
 tb/tb_axis_serdes_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/axis_serdes_tx_if.sv
// axis_serdes_tx_if: AXI-Stream word handshake feeding the serializer
interface axis_serdes_tx_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  valid;
  logic                  ready;
  modport master (output tdata, valid, input ready);
  modport slave  (input tdata, valid, output ready);
endinterface

// File: rtl/axis_serdes_tx.sv
// axis_serdes_tx: trains the line after reset, then sends framed words (start, data LSB first, even parity, stop)
module axis_serdes_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int TRAIN_CYCLES = 64
) (
  input  logic            s_axis_aclk,
  input  logic            s_axis_reset_n,
  axis_serdes_tx_if.slave s_axis,
  output logic            serial_out,
  output logic            tx_active,
  output logic            train_done
);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int TW = $clog2(TRAIN_CYCLES + 1);
  typedef enum logic [2:0] {TRAIN, IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state_q, state_d;
  logic [TW-1:0]         train_q, train_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  par_q, par_d;
  logic                  serial_q, serial_d;
  logic                  accept;
  // status outputs decode the registered state only, so inputs never reach them combinationally
  assign s_axis.ready = state_q == IDLE || state_q == STOP;
  assign tx_active    = state_q == START || state_q == DATA || state_q == PARITY || state_q == STOP;
  assign train_done   = state_q != TRAIN;
  assign serial_out   = serial_q;
  assign accept       = s_axis.ready && s_axis.valid;
  // next state and the line value for the coming cycle; train_q counts toggles already emitted
  always_comb begin
    state_d  = state_q;
    train_d  = train_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    par_d    = par_q;
    serial_d = 1'b0;
    if (accept) begin
      sh_d  = s_axis.tdata;
      par_d = ^s_axis.tdata;
    end
    case (state_q)
      TRAIN: begin
        if (train_q == TW'(TRAIN_CYCLES)) state_d = IDLE;
        else begin
          serial_d = ~train_q[0];
          train_d  = train_q + 1'b1;
        end
      end
      IDLE: begin
        state_d  = accept ? START : IDLE;
        serial_d = accept;
      end
      START: begin
        state_d  = DATA;
        serial_d = sh_q[0];
        sh_d     = sh_q >> 1;
        bit_d    = '0;
      end
      DATA: begin
        if (bit_q == BW'(DATA_WIDTH - 1)) begin
          state_d  = PARITY;
          serial_d = par_q;
        end else begin
          serial_d = sh_q[0];
          sh_d     = sh_q >> 1;
          bit_d    = bit_q + 1'b1;
        end
      end
      PARITY: state_d = STOP;
      STOP: begin
        state_d  = accept ? START : IDLE;
        serial_d = accept;
      end
      default: state_d = TRAIN;
    endcase
  end
  // state, counters, shift register and line flop; reset aborts any frame and restarts training
  always_ff @(posedge s_axis_aclk or negedge s_axis_reset_n) begin
    if (!s_axis_reset_n) begin
      state_q  <= TRAIN;
      train_q  <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      train_q  <= train_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      serial_q <= serial_d;
    end
  end
endmodule

// File: tb/tb_axis_serdes_tx.sv
// tb_axis_serdes_tx: random and directed traffic checked every cycle against a timeline model of the line
module tb_axis_serdes_tx;
  localparam int W = 32, T = 64;
  logic clk = 1'b0, rst_n = 1'b1;
  logic serial_out, tx_active, train_done;
  axis_serdes_tx_if #(.DATA_WIDTH(W)) s();
  axis_serdes_tx #(.DATA_WIDTH(W), .TRAIN_CYCLES(T)) dut (
    .s_axis_aclk(clk), .s_axis_reset_n(rst_n), .s_axis(s),
    .serial_out(serial_out), .tx_active(tx_active), .train_done(train_done)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, got, exp);
    end
  endtask
  // full frame as it must appear on the line, index 0 first
  function automatic logic [34:0] frame_of(input logic [31:0] w);
    return {1'b0, ^w, w, 1'b1};
  endfunction
  // timeline model: cycle c after reset release, fs = cycle of the current frame's start bit
  int c = 0, fs = -1;
  logic [31:0] fw = '0;
  always @(negedge clk) begin
    logic [34:0] fr;
    int o;
    logic es, er, ea, ed;
    if (!rst_n) begin
      chk("rst_serial", serial_out, 0);
      chk("rst_ready", s.ready, 0);
      chk("rst_active", tx_active, 0);
      chk("rst_done", train_done, 0);
      c = 0;
      fs = -1;
    end else begin
      o  = fs < 0 ? -1 : c - fs;
      fr = frame_of(fw);
      ea = o >= 0 && o <= 34;
      es = c < T ? ((c % 2) == 0) : ea ? fr[o] : 1'b0;
      er = c >= T && (!ea || o == 34);
      ed = c >= T;
      chk("cyc_serial", serial_out, es);
      chk("cyc_ready", s.ready, er);
      chk("cyc_active", tx_active, ea);
      chk("cyc_done", train_done, ed);
      if (er && s.valid === 1'b1) begin
        fs = c + 1;
        fw = s.tdata;
      end
      c++;
    end
  end
  task automatic send(input logic [31:0] w, input logic nv, input logic [31:0] nd);
    int n = 0;
    @(posedge clk); #1;
    s.valid = 1'b1;
    s.tdata = w;
    do begin @(negedge clk); n++; end while (s.ready !== 1'b1 && n < 100);
    chk("send_ready", s.ready, 1);
    @(posedge clk); #1;
    s.valid = nv;
    s.tdata = nd;
  endtask
  task automatic cap(input int n, input bit drop, output logic [69:0] f, output int act, output int r0);
    f = '0; act = 0; r0 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      f[i] = serial_out;
      act += int'(tx_active);
      r0  += int'(s.ready == 1'b0);
      if (i == 34 && drop) begin
        @(posedge clk); #1;
        s.valid = 1'b0;
      end
    end
  endtask
  task automatic train_len(input string nm);
    int n = -1;
    do begin @(negedge clk); n++; end while (s.ready !== 1'b1 && n < 200);
    chk(nm, n, T);
    chk({nm, "_done"}, train_done, 1);
  endtask
  initial begin
    logic [69:0] f;
    int act, r0, hs, guard;
    s.valid = 1'b0;
    s.tdata = '0;
    chk("pin_beef", frame_of(32'hDEADBEEF), 35'h1BD5B7DDF);
    chk("pin_one", frame_of(32'h1), 35'h200000003);
    #2 rst_n = 1'b0;
    s.valid = 1'b1;
    s.tdata = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    train_len("train_len");
    @(posedge clk); #1;
    s.valid = 1'b0;
    s.tdata = $urandom;
    cap(35, 1'b0, f, act, r0);
    chk("beef_line", f[34:0], 35'h1BD5B7DDF);
    chk("beef_ready_low", r0, 34);
    chk("beef_active", act, 35);
    send(32'h1, 1'b0, $urandom);
    cap(35, 1'b0, f, act, r0);
    chk("one_line", f[34:0], 35'h200000003);
    send(32'hDEADBEEF, 1'b1, 32'h12345678);
    cap(70, 1'b1, f, act, r0);
    chk("b2b_first", f[34:0], frame_of(32'hDEADBEEF));
    chk("b2b_second", f[69:35], frame_of(32'h12345678));
    chk("b2b_active", act, 70);
    hs = 0;
    guard = 0;
    while (hs < 100 && guard < 20000) begin
      @(posedge clk); #1;
      s.valid = 1'($urandom_range(0, 1));
      s.tdata = $urandom;
      @(negedge clk);
      if (s.ready === 1'b1 && s.valid === 1'b1) hs++;
      guard++;
    end
    chk("rand_words", hs, 100);
    @(posedge clk); #1;
    s.valid = 1'b0;
    repeat (40) @(negedge clk);
    send(32'hA5C3F00F, 1'b0, $urandom);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_serial", serial_out, 0);
    chk("abort_ready", s.ready, 0);
    chk("abort_active", tx_active, 0);
    chk("abort_done", train_done, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    train_len("retrain_len");
    send(32'h13572468, 1'b0, $urandom);
    cap(35, 1'b0, f, act, r0);
    chk("after_abort_line", f[34:0], frame_of(32'h13572468));
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
